// File: rtl/ccff_chain_loader.sv
// Streams host bitstream words MSB-first into a configuration flip-flop chain,
// with stall timeout and parity over the bits returned from the chain tail.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int STALL_MAX = 1024
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              old_parity
);
    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int SW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] word_reg, word_next;
    logic              word_valid_reg, word_valid_next;
    logic [IW-1:0]     index_reg, index_next;
    logic [BW-1:0]     bits_sent_reg, bits_sent_next;
    logic [SW-1:0]     stall_reg, stall_next;
    logic              err_reg, err_next;
    logic              parity_acc_reg, parity_acc_next;
    logic              old_parity_reg, old_parity_next;

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state_reg      <= IDLE;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
            index_reg      <= '0;
            bits_sent_reg  <= '0;
            stall_reg      <= '0;
            err_reg        <= 1'b0;
            parity_acc_reg <= 1'b0;
            old_parity_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            word_reg       <= word_next;
            word_valid_reg <= word_valid_next;
            index_reg      <= index_next;
            bits_sent_reg  <= bits_sent_next;
            stall_reg      <= stall_next;
            err_reg        <= err_next;
            parity_acc_reg <= parity_acc_next;
            old_parity_reg <= old_parity_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        word_next       = word_reg;
        word_valid_next = word_valid_reg;
        index_next      = index_reg;
        bits_sent_next  = bits_sent_reg;
        stall_next      = stall_reg;
        err_next        = err_reg;
        parity_acc_next = parity_acc_reg;
        old_parity_next = old_parity_reg;
        cfg_ready       = 1'b0;
        ccff_shift_en   = 1'b0;
        ccff_head       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next      = LOAD;
                    word_valid_next = 1'b0;
                    index_next      = '0;
                    bits_sent_next  = '0;
                    stall_next      = '0;
                    err_next        = 1'b0;
                    parity_acc_next = 1'b0;
                end
            end
            LOAD: begin
                cfg_ready = !word_valid_reg;
                if (word_valid_reg) begin
                    ccff_shift_en   = 1'b1;
                    ccff_head       = word_reg[index_reg];
                    bits_sent_next  = bits_sent_reg + BW'(1);
                    parity_acc_next = parity_acc_reg ^ ccff_tail;
                    index_next      = index_reg - IW'(1);
                    if (index_reg == '0) begin
                        word_valid_next = 1'b0;
                    end
                    // Chain full: drop whatever low bits of this word remain.
                    if (bits_sent_next == BW'(CHAIN_LEN)) begin
                        state_next      = DONE;
                        word_valid_next = 1'b0;
                        old_parity_next = parity_acc_next;
                    end
                end else if (cfg_valid) begin
                    word_next       = cfg_data;
                    word_valid_next = 1'b1;
                    index_next      = IW'(WORD_W - 1);
                    stall_next      = '0;
                end else begin
                    stall_next = stall_reg + SW'(1);
                    if (stall_next == SW'(STALL_MAX)) begin
                        err_next        = 1'b1;
                        state_next      = IDLE;
                        old_parity_next = parity_acc_reg;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy       = (state_reg == LOAD);
    assign done       = (state_reg == DONE);
    assign err        = err_reg;
    assign old_parity = old_parity_reg;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench: three loader instances (16/12/64-bit chains) with
// behavioural chain models and a scoreboard of expected head bits.
module tb_ccff_chain_loader;
    localparam int LENS [3] = '{16, 12, 64};

    logic       clk;
    logic       prog_reset_n;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       start_v   [3];
    logic       ready_v   [3];
    logic       head_v    [3];
    logic       shift_v   [3];
    logic       tail_v    [3];
    logic       busy_v    [3];
    logic       done_v    [3];
    logic       err_v     [3];
    logic       opar_v    [3];

    logic [63:0] chain  [3];
    logic        pre_en [3];
    logic [63:0] pre_val;

    logic       exp_q [$];
    logic [7:0] word_tab [0:15];
    int         n_checks = 0;
    int         n_fail   = 0;

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .STALL_MAX(4)) u16 (
        .prog_clk(clk), .prog_reset_n(prog_reset_n), .start(start_v[0]),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_v[0]),
        .ccff_head(head_v[0]), .ccff_shift_en(shift_v[0]), .ccff_tail(tail_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .old_parity(opar_v[0]));

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .STALL_MAX(4)) u12 (
        .prog_clk(clk), .prog_reset_n(prog_reset_n), .start(start_v[1]),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_v[1]),
        .ccff_head(head_v[1]), .ccff_shift_en(shift_v[1]), .ccff_tail(tail_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .old_parity(opar_v[1]));

    ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(8), .STALL_MAX(16)) u64 (
        .prog_clk(clk), .prog_reset_n(prog_reset_n), .start(start_v[2]),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_v[2]),
        .ccff_head(head_v[2]), .ccff_shift_en(shift_v[2]), .ccff_tail(tail_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]), .old_parity(opar_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Chain models: bit 0 is the head end, bit LEN-1 drives the tail.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (pre_en[k]) chain[k] <= pre_val;
            else if (shift_v[k]) chain[k] <= {chain[k][62:0], head_v[k]};
        end
    end

    assign tail_v[0] = chain[0][15];
    assign tail_v[1] = chain[1][11];
    assign tail_v[2] = chain[2][63];

    function automatic logic [63:0] len_mask(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    task automatic test_reset();
        prog_reset_n = 1'b0;
        cfg_valid    = 1'b0;
        cfg_data     = 8'h00;
        pre_val      = 64'd0;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            pre_en[k]  = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) pre_en[k] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({ready_v[k], shift_v[k], head_v[k], busy_v[k], done_v[k], err_v[k], opar_v[k]} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_outputs inst=%0d got %b want 0000000", k,
                         {ready_v[k], shift_v[k], head_v[k], busy_v[k], done_v[k], err_v[k], opar_v[k]});
            end
        end
        @(negedge clk);
        prog_reset_n = 1'b1;
        $display("reset applied to all instances");
    endtask

    // Streams word_tab[0..nwords-1]; gap>0 inserts random cfg_valid gaps,
    // poke pulses start while the load is in progress.
    task automatic test_stream(input int sel, input int nwords, input int gap, input bit poke);
        logic exp_par;
        logic eb;
        int   len, wi, shifts, last_shift, done_cyc, busy_cyc;
        bit   fin;
        len     = LENS[sel];
        exp_par = ^(chain[sel] & len_mask(len));
        exp_q.delete();
        @(negedge clk);
        cfg_valid    = 1'b0;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        wi = 0; shifts = 0; last_shift = -1; done_cyc = -1; busy_cyc = 0; fin = 0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            start_v[sel] = poke && (cyc >= 3) && (cyc <= 10);
            if (wi < nwords && (gap == 0 || $urandom_range(gap, 0) == 0)) begin
                cfg_valid = 1'b1;
                cfg_data  = word_tab[wi];
            end else begin
                cfg_valid = 1'b0;
            end
            #1;
            if (done_v[sel]) begin
                done_cyc = cyc;
                fin      = 1;
            end
            if (busy_v[sel]) busy_cyc++;
            if (cfg_valid && ready_v[sel]) begin
                for (int b = 7; b >= 0; b--) exp_q.push_back(cfg_data[b]);
                wi++;
            end
            if (shift_v[sel]) begin
                shifts++;
                last_shift = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL head_bit inst=%0d shift=%0d got %b want none (unexpected shift)", sel, shifts, head_v[sel]);
                end else begin
                    eb = exp_q.pop_front();
                    if (head_v[sel] !== eb) begin
                        n_fail++;
                        $display("FAIL head_bit inst=%0d shift=%0d got %b want %b", sel, shifts, head_v[sel], eb);
                    end
                end
            end
            @(negedge clk);
        end
        start_v[sel] = 1'b0;
        cfg_valid    = 1'b0;
        #1;
        n_checks++;
        if (fin !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout inst=%0d got no done want done within 600 cycles", sel);
        end
        n_checks++;
        if (shifts !== len) begin
            n_fail++;
            $display("FAIL shift_count inst=%0d got %0d want %0d", sel, shifts, len);
        end
        n_checks++;
        if (done_cyc !== last_shift + 1) begin
            n_fail++;
            $display("FAIL done_latency inst=%0d got cycle %0d want %0d", sel, done_cyc, last_shift + 1);
        end
        n_checks++;
        if (exp_q.size() !== nwords * 8 - len) begin
            n_fail++;
            $display("FAIL discarded_bits inst=%0d got %0d want %0d", sel, exp_q.size(), nwords * 8 - len);
        end
        if (gap == 0) begin
            n_checks++;
            if (busy_cyc !== len + nwords) begin
                n_fail++;
                $display("FAIL load_cycles inst=%0d got %0d want %0d", sel, busy_cyc, len + nwords);
            end
        end
        n_checks++;
        if ({busy_v[sel], done_v[sel], ready_v[sel], shift_v[sel], err_v[sel]} !== 5'b0) begin
            n_fail++;
            $display("FAIL after_done inst=%0d busy/done/ready/shift/err got %b want 00000", sel,
                     {busy_v[sel], done_v[sel], ready_v[sel], shift_v[sel], err_v[sel]});
        end
        n_checks++;
        if (opar_v[sel] !== exp_par) begin
            n_fail++;
            $display("FAIL old_parity inst=%0d got %b want %b", sel, opar_v[sel], exp_par);
        end
        $display("load inst=%0d words=%0d shifts=%0d parity=%b", sel, wi, shifts, opar_v[sel]);
    endtask

    task automatic test_head_sequence();
        word_tab[0] = 8'hA5;
        word_tab[1] = 8'h3C;
        test_stream(0, 2, 0, 0);
    endtask

    task automatic test_parity();
        @(negedge clk);
        pre_val   = 64'h0000_0000_0000_0490;
        pre_en[0] = 1'b1;
        @(negedge clk);
        pre_en[0] = 1'b0;
        word_tab[0] = 8'h6E;
        word_tab[1] = 8'hC1;
        test_stream(0, 2, 0, 0);
        n_checks++;
        if (opar_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_three_ones got %b want 1", opar_v[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        int shifts;
        bit saw_done;
        @(negedge clk);
        cfg_valid  = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cfg_valid  = 1'b1;
        cfg_data   = 8'hFF;
        shifts     = 0;
        for (int c = 0; c < 20 && shifts < 5; c++) begin
            #1;
            if (shift_v[0]) shifts++;
            @(negedge clk);
        end
        n_checks++;
        if (shifts !== 5) begin
            n_fail++;
            $display("FAIL partial_shifts got %0d want 5", shifts);
        end
        prog_reset_n = 1'b0;
        cfg_valid    = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ready_v[0], shift_v[0], head_v[0], busy_v[0], done_v[0], err_v[0], opar_v[0]} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid_load got %b want 0000000",
                     {ready_v[0], shift_v[0], head_v[0], busy_v[0], done_v[0], err_v[0], opar_v[0]});
        end
        @(negedge clk);
        prog_reset_n = 1'b1;
        saw_done     = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (done_v[0] || busy_v[0]) saw_done = 1;
            @(negedge clk);
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL no_done_after_abort got activity want idle");
        end
        $display("reset during load after %0d shifts", shifts);
        word_tab[0] = 8'h96;
        word_tab[1] = 8'h0F;
        test_stream(0, 2, 0, 1);
    endtask

    task automatic test_stall_timeout();
        int  wi, starve;
        bit  fin, saw_done;
        @(negedge clk);
        cfg_valid  = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        saw_done   = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (done_v[0]) saw_done = 1;
            n_checks++;
            if ({busy_v[0], err_v[0]} !== 2'b10) begin
                n_fail++;
                $display("FAIL stall_cycle%0d busy/err got %b want 10", c, {busy_v[0], err_v[0]});
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if ({busy_v[0], err_v[0], done_v[0], saw_done, opar_v[0]} !== 5'b01000) begin
            n_fail++;
            $display("FAIL stall_timeout busy/err/done/saw_done/parity got %b want 01000",
                     {busy_v[0], err_v[0], done_v[0], saw_done, opar_v[0]});
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (err_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky got %b want 1", err_v[0]);
        end
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        #1;
        n_checks++;
        if ({busy_v[0], err_v[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL err_clear_on_start busy/err got %b want 10", {busy_v[0], err_v[0]});
        end
        @(negedge clk);
        // Three starved cycles before each word never reach the limit of four.
        wi = 0; starve = 1; fin = 0;
        cfg_data = 8'h5A;
        for (int c = 0; c < 60 && !fin; c++) begin
            cfg_valid = (starve >= 3) && (wi < 2);
            #1;
            if (done_v[0]) fin = 1;
            if (cfg_valid && ready_v[0]) begin
                wi++;
                starve = 0;
            end else if (ready_v[0]) begin
                starve++;
            end
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        n_checks++;
        if ({fin, err_v[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_reset_by_word done/err got %b want 10", {fin, err_v[0]});
        end
        $display("stall timeout and stall-counter restart exercised");
    endtask

    task automatic test_partial_word();
        word_tab[0] = 8'hFF;
        word_tab[1] = 8'h0F;
        test_stream(1, 2, 0, 0);
    endtask

    task automatic test_random_gaps();
        for (int i = 0; i < 8; i++) word_tab[i] = 8'($urandom_range(255, 0));
        test_stream(2, 8, 3, 0);
    endtask

    initial begin
        test_reset();
        test_head_sequence();
        test_parity();
        test_reset_mid_load();
        test_stall_timeout();
        test_partial_word();
        test_random_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64, giving the number of configuration bits in the downstream chain (range 1..65535).
REQ-002 SHALL have parameter WORD_W, default 8, giving the width of bitstream words accepted from the host (range 1..32).
REQ-003 SHALL have parameter STALL_MAX, default 1024, giving the maximum number of consecutive starved cycles tolerated in LOAD (range 1..65535).
REQ-004 SHALL have port prog_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port prog_reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begin a chain load; honoured only in IDLE.
REQ-007 SHALL have port cfg_data, input, WORD_W bits: bitstream word, shifted MSB first.
REQ-008 SHALL have port cfg_valid, input, 1 bit: cfg_data holds a valid word.
REQ-009 SHALL have port cfg_ready, output, 1 bit: loader accepts a word this cycle.
REQ-010 SHALL have port ccff_head, output, 1 bit: serial configuration bit to the chain head.
REQ-011 SHALL have port ccff_shift_en, output, 1 bit: chain shifts ccff_head in at the next prog_clk edge (clock-gate enable).
REQ-012 SHALL have port ccff_tail, input, 1 bit: serial bit returned from the chain tail.
REQ-013 SHALL have port busy, output, 1 bit: high in LOAD.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-015 SHALL have port err, output, 1 bit: sticky stall-timeout flag.
REQ-016 SHALL have port old_parity, output, 1 bit: XOR of all ccff_tail bits shifted out during the last load.

Function
REQ-017 SHALL implement states IDLE, LOAD and DONE.
REQ-018 IDLE: on start=1, SHALL go to LOAD and clear the bit counter, word-valid flag, stall counter, err and the parity accumulator.
REQ-019 LOAD: SHALL drive cfg_ready=1 exactly when the word register is empty; a word transfers when cfg_valid and cfg_ready are both 1 on the same edge.
REQ-020 Each accepted word SHALL set word-valid and reset the in-word bit index to WORD_W-1.
REQ-021 LOAD with word-valid=1: SHALL drive ccff_shift_en=1 and ccff_head=word[index] combinationally.
REQ-022 Each such edge SHALL increment bits_sent and decrement index; when index was 0, word-valid SHALL clear.
REQ-023 The design SHALL accept one bubble cycle per word; ccff_shift_en=0 during bubbles, so the chain does not shift.
REQ-024 On every shifting edge, old_parity accumulator SHALL XOR in ccff_tail.
REQ-025 When a shift makes bits_sent equal CHAIN_LEN, SHALL go to DONE, clear word-valid and discard any unsent low bits of that word.
REQ-026 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-027 Stall counter: SHALL increment on each LOAD cycle with word-valid=0 and cfg_valid=0, and reset to 0 on any accepted word.
REQ-028 When the stall counter reaches STALL_MAX, SHALL set err=1, go to IDLE and not assert done.
REQ-029 Outside LOAD: SHALL hold cfg_ready=0, ccff_shift_en=0 and ccff_head=0.
REQ-030 SHALL ignore start in LOAD or DONE.
REQ-031 err SHALL remain set until the next honoured start or reset.
REQ-032 old_parity SHALL update only at load end (DONE or timeout) and otherwise hold.
REQ-033 bits_sent SHALL be ceil(log2(CHAIN_LEN+1)) bits wide and never exceed CHAIN_LEN.

Reset
REQ-034 With prog_reset_n=0 at an edge, SHALL go to IDLE with cfg_ready, ccff_shift_en, ccff_head, busy, done, err and old_parity all 0, and all counters at 0.
REQ-035 Reset during LOAD SHALL abort immediately with no done pulse; the chain holds a partial load.

Verification
REQ-036 CHAIN_LEN=16, WORD_W=8: start, then words 0xA5 and 0x3C with no gaps -> ccff_head sequence 1010010100111100 over 16 shift_en cycles, one bubble between words, done one cycle after the 16th shift, then IDLE.
REQ-037 CHAIN_LEN=12: words 0xFF and 0x0F -> 12 shifts 111111110000, low nibble discarded, done pulses, cfg_ready=0 afterwards.
REQ-038 STALL_MAX=4: start, no cfg_valid -> err=1 after 4 starved cycles, busy=0, done never asserted, and the next start clears err.
REQ-039 Chain model preloaded with 16 bits containing three 1s, then a full load -> old_parity=1 after done.
REQ-040 prog_reset_n=0 after 5 shifts -> next cycle all outputs 0, no done; start during LOAD -> no effect on bits_sent.
REQ-041 Random cfg_valid gaps with CHAIN_LEN=64 -> the shifted-out ccff_head stream equals the concatenated words MSB first, with exactly 64 shift_en cycles.
